// File: rtl/proc_control_fsm.sv
// Multicycle T0..T3 control sequencer for the bus-based processor: register-select codes,
// decoder enables, A/G/IR strobes, bus source selects and Done. Optional mvnz opcode: CTRL_MVNZ_EN.
module proc_control_fsm #(
    parameter int unsigned IR_W  = 9,
    parameter int unsigned SEL_W = 3
) (
    input  logic             Clock,
    input  logic             Resetn,
    input  logic             Run,
    input  logic [IR_W-1:0]  IR,
    input  logic             GNZ,
    output logic             IRin,
    output logic [SEL_W-1:0] RinSel,
    output logic             RinEn,
    output logic [SEL_W-1:0] RoutSel,
    output logic             RoutEn,
    output logic             Ain,
    output logic             Gin,
    output logic             Gout,
    output logic             DINout,
    output logic             AddSub,
    output logic             Done,
    output logic [1:0]       Tstep
);

    localparam int unsigned OP_W = 3;
    localparam logic [OP_W-1:0] OP_MV   = 3'b000;
    localparam logic [OP_W-1:0] OP_MVI  = 3'b001;
    localparam logic [OP_W-1:0] OP_ADD  = 3'b010;
    localparam logic [OP_W-1:0] OP_SUB  = 3'b011;
`ifdef CTRL_MVNZ_EN
    localparam logic [OP_W-1:0] OP_MVNZ = 3'b100;
`endif

    typedef enum logic [1:0] {
        T0 = 2'd0,
        T1 = 2'd1,
        T2 = 2'd2,
        T3 = 2'd3
    } state_t;

    state_t            r_state;
    state_t            w_next;
    logic [OP_W-1:0]   w_op;
    logic [SEL_W-1:0]  w_x;
    logic [SEL_W-1:0]  w_y;
    logic              w_is_alu;

    assign w_op     = IR[8:6];
    assign w_x      = SEL_W'(IR[5:3]);
    assign w_y      = SEL_W'(IR[2:0]);
    assign w_is_alu = (w_op == OP_ADD) || (w_op == OP_SUB);
    assign Tstep    = 2'(r_state);

`ifndef CTRL_MVNZ_EN
    logic w_unused_gnz;
    assign w_unused_gnz = GNZ;
`endif

    // Timestep register; reset returns to T0 without waiting for a clock
    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            r_state <= T0;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state and strobe decode
    always_comb begin
        w_next  = T0;
        IRin    = 1'b0;
        RinSel  = '0;
        RinEn   = 1'b0;
        RoutSel = '0;
        RoutEn  = 1'b0;
        Ain     = 1'b0;
        Gin     = 1'b0;
        Gout    = 1'b0;
        DINout  = 1'b0;
        AddSub  = 1'b0;
        Done    = 1'b0;
        case (r_state)
            T0: begin
                IRin   = Run & Resetn;
                w_next = Run ? T1 : T0;
            end
            T1: begin
                case (w_op)
                    OP_MV: begin
                        RoutSel = w_y;
                        RoutEn  = 1'b1;
                        RinSel  = w_x;
                        RinEn   = 1'b1;
                        Done    = 1'b1;
                    end
                    OP_MVI: begin
                        DINout = 1'b1;
                        RinSel = w_x;
                        RinEn  = 1'b1;
                        Done   = 1'b1;
                    end
                    OP_ADD, OP_SUB: begin
                        RoutSel = w_x;
                        RoutEn  = 1'b1;
                        Ain     = 1'b1;
                        w_next  = T2;
                    end
`ifdef CTRL_MVNZ_EN
                    OP_MVNZ: begin
                        Done = 1'b1;
                        if (GNZ) begin
                            RoutSel = w_y;
                            RoutEn  = 1'b1;
                            RinSel  = w_x;
                            RinEn   = 1'b1;
                        end
                    end
`endif
                    default: begin
                        Done = 1'b1;
                    end
                endcase
            end
            T2: begin
                // Non-ALU opcodes here are glitch recovery: stay silent, return to T0
                if (w_is_alu) begin
                    RoutSel = w_y;
                    RoutEn  = 1'b1;
                    Gin     = 1'b1;
                    AddSub  = IR[6];
                    w_next  = T3;
                end
            end
            T3: begin
                if (w_is_alu) begin
                    Gout   = 1'b1;
                    RinSel = w_x;
                    RinEn  = 1'b1;
                    Done   = 1'b1;
                end
            end
            default: begin
                w_next = T0;
            end
        endcase
    end

endmodule

// File: tb/tb_proc_control_fsm.sv
// Scoreboard bench for proc_control_fsm: a reference model pushes expected per-cycle
// output vectors per instruction; a negedge monitor pops and compares.
module tb_proc_control_fsm;

    typedef struct packed {
        logic       irin;
        logic [2:0] rin_sel;
        logic       rin_en;
        logic [2:0] rout_sel;
        logic       rout_en;
        logic       ain;
        logic       gin;
        logic       gout;
        logic       dinout;
        logic       addsub;
        logic       done;
        logic [1:0] tstep;
    } vec_t;

    logic       Clock = 1'b0;
    logic       Resetn;
    logic       Run;
    logic [8:0] IR;
    logic       GNZ;
    logic       IRin, RinEn, RoutEn, Ain, Gin, Gout, DINout, AddSub, Done;
    logic [2:0] RinSel, RoutSel;
    logic [1:0] Tstep;

    proc_control_fsm #(.IR_W(9), .SEL_W(3)) dut (
        .Clock(Clock), .Resetn(Resetn), .Run(Run), .IR(IR), .GNZ(GNZ),
        .IRin(IRin), .RinSel(RinSel), .RinEn(RinEn), .RoutSel(RoutSel),
        .RoutEn(RoutEn), .Ain(Ain), .Gin(Gin), .Gout(Gout), .DINout(DINout),
        .AddSub(AddSub), .Done(Done), .Tstep(Tstep)
    );

    always #5 Clock = ~Clock;

    int   n_cmp = 0;
    int   n_err = 0;
    int   n_done_exp = 0;
    int   n_done_act = 0;
    int   rem = 0;
    bit   mon_on = 1'b0;
    bit   pend = 1'b0;
    logic [8:0] pend_ir;
    logic       pend_gnz;
    vec_t exp_q[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, req, $time);
        end
    endtask

    function automatic vec_t dut_vec();
        vec_t v;
        v = {IRin, RinSel, RinEn, RoutSel, RoutEn, Ain, Gin, Gout, DINout, AddSub, Done, Tstep};
        return v;
    endfunction

    // Reference model: the instruction's cycle-by-cycle strobes, straight from the opcode table
    task automatic push_instr(input logic [8:0] instr, input logic gnz);
        vec_t       v;
        logic [2:0] op, x, y;
        int         len;
        op = instr[8:6]; x = instr[5:3]; y = instr[2:0];
        v = '0; v.irin = 1'b1; v.tstep = 2'd0;
        exp_q.push_back(v);
        v = '0; v.tstep = 2'd1; v.done = 1'b1; len = 2;
        if (op == 3'd0) begin
            v.rout_sel = y; v.rout_en = 1'b1; v.rin_sel = x; v.rin_en = 1'b1;
        end else if (op == 3'd1) begin
            v.dinout = 1'b1; v.rin_sel = x; v.rin_en = 1'b1;
        end else if (op == 3'd2 || op == 3'd3) begin
            len = 4;
            v.done = 1'b0; v.rout_sel = x; v.rout_en = 1'b1; v.ain = 1'b1;
        end
`ifdef CTRL_MVNZ_EN
        else if (op == 3'd4 && gnz) begin
            v.rout_sel = y; v.rout_en = 1'b1; v.rin_sel = x; v.rin_en = 1'b1;
        end
`endif
        exp_q.push_back(v);
        if (len == 4) begin
            v = '0; v.tstep = 2'd2; v.rout_sel = y; v.rout_en = 1'b1; v.gin = 1'b1;
            v.addsub = (op == 3'd3);
            exp_q.push_back(v);
            v = '0; v.tstep = 2'd3; v.gout = 1'b1; v.rin_sel = x; v.rin_en = 1'b1; v.done = 1'b1;
            exp_q.push_back(v);
        end
        n_done_exp++;
        rem = len - 1;
        if (gnz === 1'bx) rem = rem;
    endtask

    // One clock of stimulus; IR/GNZ act as the instruction register loaded at the IRin edge
    task automatic step(input logic run, input logic [8:0] instr, input logic gnz);
        Run = run;
        if (rem == 0) begin
            if (run) begin
                push_instr(instr, gnz);
                pend = 1'b1; pend_ir = instr; pend_gnz = gnz;
            end else begin
                exp_q.push_back(vec_t'(0));
            end
        end else begin
            rem--;
        end
        @(posedge Clock); #1;
        if (pend) begin
            IR = pend_ir; GNZ = pend_gnz; pend = 1'b0;
        end
    endtask

    // Monitor: every cycle is an output presentation for this block
    always @(negedge Clock) begin
        vec_t a, e;
        if (mon_on) begin
            a = dut_vec();
            chk("bus_exclusive", 32'($countones({RoutEn, Gout, DINout}) <= 1), 32'd1);
            if (Done) n_done_act++;
            if (exp_q.size() == 0) begin
                chk("scoreboard_underflow", 32'd1, 32'd0);
            end else begin
                e = exp_q.pop_front();
                chk("cycle_vector", 32'(a), 32'(e));
            end
        end
    end

    initial begin
        Resetn = 1'b0; Run = 1'b1; IR = 9'b011_010_101; GNZ = 1'b1;
        #2;
        chk("reset_all_zero", 32'(dut_vec()), 32'd0);
        @(posedge Clock); @(posedge Clock); #1;
        chk("reset_hold_zero", 32'(dut_vec()), 32'd0);
        Resetn = 1'b1; Run = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge Clock);
            chk("idle_tstep", 32'(Tstep), 32'd0);
            chk("idle_vector", 32'(dut_vec()), 32'd0);
        end
        @(posedge Clock); #1;

        mon_on = 1'b1;
        step(1'b1, 9'b001_011_000, 1'b0);      // mvi R3
        step(1'b0, 9'b0, 1'b0);
        step(1'b0, 9'b0, 1'b0);
        step(1'b1, 9'b011_010_101, 1'b1);      // sub R2,R5
        for (int i = 0; i < 4; i++) step(1'b0, 9'b0, 1'b0);
        step(1'b1, 9'b000_001_111, 1'b0);      // mv then add, Run held high
        step(1'b1, 9'b0, 1'b0);
        step(1'b1, 9'b010_100_001, 1'b0);
        for (int i = 0; i < 3; i++) step(1'b1, 9'b0, 1'b0);
        step(1'b1, 9'b100_110_010, 1'b1);      // opcode 100, GNZ=1
        step(1'b1, 9'b0, 1'b0);
        step(1'b1, 9'b100_101_011, 1'b0);      // opcode 100, GNZ=0
        step(1'b0, 9'b0, 1'b0);
        step(1'b1, 9'b111_111_111, 1'b1);      // reserved
        step(1'b0, 9'b0, 1'b0);
        for (int i = 0; i < 600; i++)
            step(1'($urandom_range(0, 3) != 0), 9'($urandom), 1'($urandom));
        for (int i = 0; i < 8 && rem != 0; i++) step(1'b0, 9'b0, 1'b0);
        mon_on = 1'b0;
        chk("queue_drained", 32'(exp_q.size()), 32'd0);
        chk("done_count", 32'(n_done_act), 32'(n_done_exp));

        // Reset mid-add: Gin must fall without a clock edge, nothing completes afterwards
        Run = 1'b1;
        @(posedge Clock); #1;
        IR = 9'b010_011_110; Run = 1'b0;
        @(posedge Clock); #1;
        chk("midadd_t2_gin", 32'({Tstep, Gin}), 32'({2'd2, 1'b1}));
        #2; Resetn = 1'b0; #1;
        chk("midadd_reset_gin", 32'(Gin), 32'd0);
        chk("midadd_reset_vec", 32'(dut_vec()), 32'd0);
        @(posedge Clock); @(posedge Clock); #1;
        Resetn = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge Clock);
            chk("post_reset_quiet", 32'({Tstep, Gout, Done}), 32'd0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/proc_control_fsm.md
Name: proc_control_fsm

Overview:
Multicycle control unit for the simple bus-based processor. It sits directly upstream of the 3-to-8 register-enable decoders and the datapath bus mux. It sequences each instruction over timesteps T0..T3 and emits 3-bit register-select codes plus enable strobes, which the decoders expand into one-hot Rin/Rout vectors. It also drives the A/G/IR load strobes, the bus source selects and Done.

Parameters:
IR_W, 9, instruction width: opcode IR[8:6], X field IR[5:3], Y field IR[2:0]; only 9 is supported
SEL_W, 3, register-select code width fed to each decoder W input

Ports:
Clock  input  1  system clock, rising edge
Resetn  input  1  asynchronous active-low reset
Run  input  1  start request; sampled only in T0
IR  input  IR_W  output of the instruction register (loaded by IRin)
GNZ  input  1  G register non-zero flag; used only with CTRL_MVNZ_EN
IRin  output  1  load instruction register from DIN
RinSel  output  SEL_W  destination register code (decoder W)
RinEn  output  1  destination decoder enable (decoder En)
RoutSel  output  SEL_W  bus source register code (decoder W)
RoutEn  output  1  source decoder enable
Ain  output  1  load A from bus
Gin  output  1  load G from ALU
Gout  output  1  drive G onto bus
DINout  output  1  drive DIN onto bus
AddSub  output  1  ALU op: 0 = add, 1 = sub
Done  output  1  pulses high in the last cycle of each instruction
Tstep  output  2  current timestep (00=T0..11=T3), for the display path

Behaviour:
- State register Tstep is the only sequential state. Resetn=0 forces Tstep=T0 immediately, without waiting for a clock edge.
- All strobe outputs are combinational decodes of Tstep, IR and Run. With Resetn=0 and Run=0, every output is 0.
- When unused, RinSel and RoutSel are driven to 3'b000.
- Opcodes: 000 mv Rx,Ry; 001 mvi Rx,#D; 010 add Rx,Ry; 011 sub Rx,Ry; 100-111 reserved.
- T0: IRin = Run. If Run=1 the next state is T1 and IR is loaded at the same edge; otherwise Tstep stays T0.
- T1, mv: RoutSel=Y, RoutEn=1, RinSel=X, RinEn=1, Done=1; next state T0.
- T1, mvi: DINout=1, RinSel=X, RinEn=1, Done=1; next state T0.
- T1, add/sub: RoutSel=X, RoutEn=1, Ain=1; next state T2.
- T1, reserved opcode: Done=1 only; next state T0 (no-op).
- T2, add/sub: RoutSel=Y, RoutEn=1, Gin=1, AddSub=IR[6]; next state T3.
- T3, add/sub: Gout=1, RinSel=X, RinEn=1, Done=1; next state T0.
- T2 or T3 reached with a non-add/sub opcode (illegal; reachable only through a glitch): drive all outputs 0 and go to T0.
- Latency counted from the T0 cycle with Run=1: mv/mvi complete in 2 cycles, add/sub in 4. Done is high for exactly 1 cycle per instruction.
- Run is ignored in T1..T3. Run held high causes back-to-back fetches, and the T0 following Done fetches again.
- Bus exclusivity invariant: at most one of RoutEn, Gout, DINout is high in any cycle.
- Resetn asserted mid-instruction: the instruction is abandoned, no further strobes are issued, and Tstep=T0 once Resetn is released.

Optional Feature:
Macro CTRL_MVNZ_EN.
- Defined: opcode 100 is mvnz Rx,Ry. In T1, if GNZ=1 it behaves exactly as mv; if GNZ=0 it asserts Done only. Either way the next state is T0.
- Undefined: opcode 100 is a reserved no-op, and GNZ is unused.

Test Plan:
- Reset: Resetn=0 with Run=1 -> Tstep=00, all strobes 0, IRin=0. Release Resetn with Run=0 for 3 cycles -> Tstep stays 00.
- mvi: Run=1, IR=9'b001_011_000 -> T0: IRin=1. T1: DINout=1, RinSel=3, RinEn=1, Done=1. Then back to T0.
- sub: IR=9'b011_010_101 -> T1: RoutSel=2, Ain=1. T2: RoutSel=5, Gin=1, AddSub=1. T3: Gout=1, RinSel=2, RinEn=1, Done=1. Done high for 1 cycle only.
- mv back-to-back with Run held high: IR=000_001_111, then 010_100_001 -> Done at cycles 2 and 6. No cycle has two bus drivers.
- Reset mid-add: assert Resetn=0 while in T2 -> Gin drops in the same cycle (no clock edge). After release -> T0 and no Gout/Done pulse.
- Reserved opcode 100 with GNZ=1: without CTRL_MVNZ_EN -> T1 asserts Done only. With the macro -> RoutSel=Y, RinSel=X, both enables high, Done=1. With the macro and GNZ=0 -> Done only.
